i2s_codec_target: RTL and testbench
===================================

Name: i2s_codec_target

Overview:
- Codec-side (target) end of the I2S link that the CBI980 controller masters.
- Receives externally driven `codec_mclk`, `codec_lrclk` and `codec_sclk`, deserialises `codec_sdin` into 24-bit samples, and serialises 24-bit samples onto `codec_sdout`.
- Serves as the synthesizable codec model for system benches and FPGA loopback builds. Talks to sample logic through per-channel valid/ack pulses in the same style as the controller's `aud_*` interface.

Parameters:
- SAMPLE_BITS, 24, sample width captured and driven per channel.
- SLOT_BITS, 32, expected sclk periods per channel slot; `SLOT_BITS` ≥ `SAMPLE_BITS`+1.
- SYNC_STAGES, 2, synchroniser depth for `codec_sclk`, `codec_lrclk` and `codec_sdin`.

Ports:
- clk  in  1  system clock; must be ≥ 4× the `codec_sclk` frequency.
- rst  in  1  asynchronous, active-high reset.
- codec_rstn  in  1  codec reset from the controller; low holds the block in IDLE.
- codec_mclk  in  1  accepted and unused, kept for pin compatibility.
- codec_lrclk  in  1  word select; 0 = channel 0 (left), 1 = channel 1 (right).
- codec_sclk  in  1  bit clock.
- codec_sdin  in  1  serial data from the controller, sampled on sclk rising edges.
- codec_sdout  out  1  serial data to the controller, changes on sclk falling edges.
- rx_data  out  SAMPLE_BITS  last received sample.
- rx_vld  out  2  one-clk pulse per channel when `rx_data` is valid.
- tx_data0  in  SAMPLE_BITS  channel 0 sample to transmit.
- tx_data1  in  SAMPLE_BITS  channel 1 sample to transmit.
- tx_ack  out  2  one-clk pulse per channel when the corresponding `tx_data` is consumed.
- locked  out  1  high once frame alignment is acquired.

Behaviour:
- Reset values: `codec_sdout`=0, `rx_data`=0, `rx_vld`=0, `tx_ack`=0, `locked`=0, all counters 0, state IDLE.
- Input conditioning:
  - `codec_sclk`, `codec_lrclk` and `codec_sdin` each pass through SYNC_STAGES flops.
  - Rise and fall events come from the synchronised `codec_sclk` versus its previous value.
  - Events are single-clk strobes.
- Rising edge processing: sample `lr_s` and `sd_s`. "WS change" means `lr_s` differs from the `lr_s` value sampled at the previous rise.
- States:
  - IDLE: `codec_rstn`=0 or not yet aligned; `codec_sdout`=0; no `rx_vld`/`tx_ack`. Goes to ALIGN when `codec_rstn`=1.
  - ALIGN: on the first WS change, set `ch`=`lr_s`, `bitcnt`=0, `locked`=1, go to RUN. Partial frames before this are discarded.
  - RUN, on each rising edge:
    - On WS change: `ch`←`lr_s`, `bitcnt`←0. The bit sampled on this edge belongs to the old slot and is ignored (I2S one-bit delay).
    - Otherwise, if `bitcnt` < SAMPLE_BITS, shift `sd_s` into the rx shift register MSB-first.
    - `bitcnt` saturates at SLOT_BITS.
    - When the bit at `bitcnt`=SAMPLE_BITS−1 is shifted in, the next clk sets `rx_data` to the full word and pulses `rx_vld[ch]` for one clk.
- Transmit path:
  - On the first falling edge after a WS change, load the tx shift register from `tx_data0`/`tx_data1` per `ch`, drive its MSB on `codec_sdout`, and pulse `tx_ack[ch]` in the same clk.
  - On each subsequent falling edge, shift left.
  - Once SAMPLE_BITS bits have been driven, `codec_sdout`=0 for the rest of the slot.
- Long and short slots:
  - Slots longer than SLOT_BITS: extra bits are ignored and `sdout` stays 0.
  - Short slots (WS change before SAMPLE_BITS bits): no `rx_vld` for the truncated word; the new slot starts normally.
- `codec_rstn` falling mid-frame: within SYNC_STAGES+1 clk, enter IDLE, set `locked`=0 and `codec_sdout`=0. No `rx_vld`/`tx_ack` is emitted for the aborted slot. Alignment is re-acquired from ALIGN.
- `rst` asserted at any time: asynchronously clears all state to the reset values.

Optional Feature:
- Macro: `I2S_TARGET_FRAME_ERR_EN`.
- When defined:
  - Adds output `slot_err` (1 bit, reset 0).
  - In RUN, a WS change with a pre-change `bitcnt` ≠ SLOT_BITS−1 sets `slot_err`=1. The first change after ALIGN is exempt.
  - `slot_err` is sticky until `rst` or `codec_rstn` low.
- When undefined: no `slot_err` port, no check logic. All other behaviour is identical.

Decomposition:
- Shared package `i2s_pkg`:
  - channel index localparams CH_L=0, CH_R=1;
  - target state encoding IDLE/ALIGN/RUN;
  - default SAMPLE_BITS and SLOT_BITS.
- One natural sub-module: `i2s_edge_sync`, containing the synchronisers plus rise/fall strobe generation. It is instantiated once and reusable by the controller's receive path.

Test Plan:
- Reset, then `codec_rstn`=1 with sclk = clk/8, 32-bit slots; before the first WS edge → `locked`=0, `codec_sdout`=0, no pulses. After the first WS change → `locked`=1.
- Controller sends L=24'hABCDEF, R=24'h123456 → `rx_vld[0]` with `rx_data`=24'hABCDEF, then `rx_vld[1]` with 24'h123456, exactly one pulse each per frame.
- `tx_data0`=24'hC0FFEE, `tx_data1`=24'h00A5A5 → sdout deserialised by the bench equals C0FFEE (left), 00A5A5 (right); bits 24–31 = 0; one `tx_ack` pulse per slot, at slot start.
- Slot of 16 sclk (WS change after 16 bits) → no `rx_vld` for that slot; the next full slot is captured correctly. With `I2S_TARGET_FRAME_ERR_EN`, `slot_err`=1 and it stays set.
- Drop `codec_rstn` at bit 10 of a left slot → `locked`=0 and sdout=0 within SYNC_STAGES+1 clk, no `rx_vld`/`tx_ack`. Re-release → realigns and captures the next full slot.
- Assert `rst` mid-slot for 1 clk → all outputs return to reset values immediately; the block resumes via ALIGN.

Source files
------------

// File: rtl/i2s_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2s_pkg                                                      |
// | Description : Shared channel indices, target state encoding and default   |
// |               sample/slot widths for the I2S link blocks.                  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package i2s_pkg;

   localparam int CH_L = 0;
   localparam int CH_R = 1;

   localparam int DEF_SAMPLE_BITS = 24;
   localparam int DEF_SLOT_BITS   = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_RUN   = 2'd2
   } tgt_state_t;

endpackage
`default_nettype wire

// File: rtl/i2s_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2s_edge_sync                                                |
// | Description : Synchronises sclk/lrclk/sdin into clk and emits one-clk     |
// |               sclk rise/fall strobes aligned with the synced lr/sd.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module i2s_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sclk,
   input  logic lrclk,
   input  logic sdin,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic lr_s,
   output logic sd_s
);

   // All three lines share one chain so lr/sd stay aligned with the sclk edge
   logic [2:0] r_sync [SYNC_STAGES];
   logic       r_sclk_prev;
   logic [2:0] w_sync_out;

   assign w_sync_out = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= 3'b000;
         end
         r_sclk_prev <= 1'b0;
      end else begin
         r_sync[0] <= {sclk, lrclk, sdin};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_sclk_prev <= w_sync_out[2];
      end
   end

   assign sclk_rise = w_sync_out[2] & ~r_sclk_prev;
   assign sclk_fall = ~w_sync_out[2] & r_sclk_prev;
   assign lr_s      = w_sync_out[1];
   assign sd_s      = w_sync_out[0];

endmodule
`default_nettype wire

// File: rtl/i2s_codec_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2s_codec_target                                             |
// | Description : Codec-side I2S target: deserialises sdin, serialises sdout. |
// |               Optional macro I2S_TARGET_FRAME_ERR_EN adds slot_err.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module i2s_codec_target
   import i2s_pkg::*;
#(
   parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
   parameter int SLOT_BITS   = DEF_SLOT_BITS,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   codec_rstn,
   input  logic                   codec_mclk,
   input  logic                   codec_lrclk,
   input  logic                   codec_sclk,
   input  logic                   codec_sdin,
   output logic                   codec_sdout,
   output logic [SAMPLE_BITS-1:0] rx_data,
   output logic [1:0]             rx_vld,
   input  logic [SAMPLE_BITS-1:0] tx_data0,
   input  logic [SAMPLE_BITS-1:0] tx_data1,
   output logic [1:0]             tx_ack,
   output logic                   locked
`ifdef I2S_TARGET_FRAME_ERR_EN
   ,
   output logic                   slot_err
`endif
);

   localparam int CNT_W = $clog2(SLOT_BITS + 1);
   localparam logic [CNT_W-1:0] c_SAMPLE      = CNT_W'(SAMPLE_BITS);
   localparam logic [CNT_W-1:0] c_SAMPLE_LAST = CNT_W'(SAMPLE_BITS - 1);
   localparam logic [CNT_W-1:0] c_SLOT        = CNT_W'(SLOT_BITS);
`ifdef I2S_TARGET_FRAME_ERR_EN
   localparam logic [CNT_W-1:0] c_SLOT_LAST   = CNT_W'(SLOT_BITS - 1);
`endif

   tgt_state_t             r_state;
   tgt_state_t             w_state_nxt;
   logic                   r_rstn_sync [SYNC_STAGES];
   logic                   w_rstn_s;
   logic                   w_rise;
   logic                   w_fall;
   logic                   w_lr_s;
   logic                   w_sd_s;
   logic                   w_ws_chg;
   logic                   w_unused_mclk;
   logic                   r_lr_prev;
   logic                   r_lr_seen;
   logic                   r_ch;
   logic [CNT_W-1:0]       r_bitcnt;
   logic [SAMPLE_BITS-1:0] r_rx_shift;
   logic [SAMPLE_BITS-1:0] r_rx_data;
   logic                   r_rx_done;
   logic [1:0]             r_rx_vld;
   logic [SAMPLE_BITS-1:0] r_tx_shift;
   logic [SAMPLE_BITS-1:0] w_tx_word;
   logic                   r_tx_pend;
   logic [1:0]             r_tx_ack;
   logic                   r_locked;
`ifdef I2S_TARGET_FRAME_ERR_EN
   logic                   r_slot_err;
`endif

   assign w_unused_mclk = codec_mclk;

   i2s_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk       (clk),
      .rst       (rst),
      .sclk      (codec_sclk),
      .lrclk     (codec_lrclk),
      .sdin      (codec_sdin),
      .sclk_rise (w_rise),
      .sclk_fall (w_fall),
      .lr_s      (w_lr_s),
      .sd_s      (w_sd_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_rstn_sync[i] <= 1'b0;
         end
      end else begin
         r_rstn_sync[0] <= codec_rstn;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_rstn_sync[i] <= r_rstn_sync[i-1];
         end
      end
   end

   assign w_rstn_s  = r_rstn_sync[SYNC_STAGES-1];
   // lr_seen blocks a false WS change against the stale reset value of lr_prev
   assign w_ws_chg  = w_rise & r_lr_seen & (w_lr_s != r_lr_prev);
   assign w_tx_word = (r_ch == 1'(CH_R)) ? tx_data1 : tx_data0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_rstn_s) w_state_nxt = ST_ALIGN;
         end
         ST_ALIGN: begin
            if (!w_rstn_s)     w_state_nxt = ST_IDLE;
            else if (w_ws_chg) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!w_rstn_s) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lr_prev  <= 1'b0;
         r_lr_seen  <= 1'b0;
         r_ch       <= 1'b0;
         r_bitcnt   <= '0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_done  <= 1'b0;
         r_rx_vld   <= 2'b00;
         r_tx_shift <= '0;
         r_tx_pend  <= 1'b0;
         r_tx_ack   <= 2'b00;
         r_locked   <= 1'b0;
`ifdef I2S_TARGET_FRAME_ERR_EN
         r_slot_err <= 1'b0;
`endif
      end else begin
         r_rx_vld <= 2'b00;
         r_tx_ack <= 2'b00;
         if (!w_rstn_s || r_state == ST_IDLE) begin
            r_lr_seen  <= 1'b0;
            r_bitcnt   <= '0;
            r_rx_done  <= 1'b0;
            r_tx_shift <= '0;
            r_tx_pend  <= 1'b0;
            r_locked   <= 1'b0;
`ifdef I2S_TARGET_FRAME_ERR_EN
            r_slot_err <= 1'b0;
`endif
         end else begin
            r_rx_done <= 1'b0;
            if (r_rx_done) begin
               r_rx_data      <= r_rx_shift;
               r_rx_vld[r_ch] <= 1'b1;
            end
            if (w_rise) begin
               r_lr_seen <= 1'b1;
               r_lr_prev <= w_lr_s;
               if (w_ws_chg) begin
                  // Bit on this edge is the old slot's LSB (one-bit delay), so drop it
                  r_ch      <= w_lr_s;
                  r_bitcnt  <= '0;
                  r_tx_pend <= 1'b1;
                  if (r_state == ST_ALIGN) r_locked <= 1'b1;
`ifdef I2S_TARGET_FRAME_ERR_EN
                  // The aligning change happens in ALIGN, so it is never checked
                  if (r_state == ST_RUN && r_bitcnt != c_SLOT_LAST) r_slot_err <= 1'b1;
`endif
               end else if (r_state == ST_RUN) begin
                  if (r_bitcnt < c_SAMPLE) begin
                     r_rx_shift <= {r_rx_shift[SAMPLE_BITS-2:0], w_sd_s};
                     if (r_bitcnt == c_SAMPLE_LAST) r_rx_done <= 1'b1;
                  end
                  if (r_bitcnt != c_SLOT) r_bitcnt <= r_bitcnt + 1'b1;
               end
            end
            // Zero-fill shifting leaves sdout low once all sample bits are out
            if (w_fall && r_state == ST_RUN) begin
               if (r_tx_pend) begin
                  r_tx_shift     <= w_tx_word;
                  r_tx_pend      <= 1'b0;
                  r_tx_ack[r_ch] <= 1'b1;
               end else begin
                  r_tx_shift <= r_tx_shift << 1;
               end
            end
         end
      end
   end

   assign codec_sdout = r_tx_shift[SAMPLE_BITS-1];
   assign rx_data     = r_rx_data;
   assign rx_vld      = r_rx_vld;
   assign tx_ack      = r_tx_ack;
   assign locked      = r_locked;
`ifdef I2S_TARGET_FRAME_ERR_EN
   assign slot_err    = r_slot_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_codec_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_i2s_codec_target                                          |
// | Description : Directed bench acting as the I2S controller, with a slot-   |
// |               level model of expected rx/tx pulses and sdout bits.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_i2s_codec_target;

   localparam logic [23:0] TX0 = 24'hC0FFEE;
   localparam logic [23:0] TX1 = 24'h00A5A5;

   typedef struct packed {
      logic        ch;
      logic [23:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        codec_rstn;
   logic        codec_mclk;
   logic        codec_lrclk;
   logic        codec_sclk;
   logic        codec_sdin;
   logic        codec_sdout;
   logic [23:0] rx_data;
   logic [1:0]  rx_vld;
   logic [23:0] tx_data0;
   logic [23:0] tx_data1;
   logic [1:0]  tx_ack;
   logic        locked;
`ifdef I2S_TARGET_FRAME_ERR_EN
   logic        slot_err;
`endif

   int   n_total = 0;
   int   n_bad   = 0;
   exp_t rx_q[$];
   exp_t tx_q[$];
   logic m_aligned  = 1'b0;
   logic prev_valid = 1'b0;
   logic prev_lr    = 1'b0;

   always #5 clk = ~clk;
   assign codec_mclk = clk;

   i2s_codec_target dut (
      .clk         (clk),
      .rst         (rst),
      .codec_rstn  (codec_rstn),
      .codec_mclk  (codec_mclk),
      .codec_lrclk (codec_lrclk),
      .codec_sclk  (codec_sclk),
      .codec_sdin  (codec_sdin),
      .codec_sdout (codec_sdout),
      .rx_data     (rx_data),
      .rx_vld      (rx_vld),
      .tx_data0    (tx_data0),
      .tx_data1    (tx_data1),
      .tx_ack      (tx_ack),
      .locked      (locked)
`ifdef I2S_TARGET_FRAME_ERR_EN
      ,
      .slot_err    (slot_err)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every rx_vld / tx_ack pulse must match the next expected slot event
   always @(negedge clk) begin : mon
      exp_t e;
      if (rx_vld !== 2'b00) begin
         if (rx_q.size() == 0) begin
            check("rx_vld_unexpected", {30'b0, rx_vld}, 32'd0);
         end else begin
            e = rx_q.pop_front();
            check("rx_vld_ch", {30'b0, rx_vld}, {30'b0, 2'b01 << e.ch});
            check("rx_data", {8'b0, rx_data}, {8'b0, e.data});
         end
      end
      if (tx_ack !== 2'b00) begin
         if (tx_q.size() == 0) begin
            check("tx_ack_unexpected", {30'b0, tx_ack}, 32'd0);
         end else begin
            e = tx_q.pop_front();
            check("tx_ack_ch", {30'b0, tx_ack}, {30'b0, 2'b01 << e.ch});
         end
      end
   end

   // One slot of len sclk periods; WS flips on the first falling edge.
   // abort_kind: 0 none, 1 drop codec_rstn, 2 pulse rst, after rise abort_at.
   task automatic send_slot(input logic lr, input logic [23:0] w, input int len,
                            input int abort_kind, input int abort_at);
      logic        cap;
      logic        aborted;
      logic [23:0] txw;
      logic [23:0] got;
      if (prev_valid && (lr != prev_lr)) m_aligned = 1'b1;
      cap     = m_aligned;
      aborted = 1'b0;
      txw     = lr ? TX1 : TX0;
      got     = '0;
      if (cap) begin
         tx_q.push_back('{ch: lr, data: txw});
         if (len > 24 && abort_kind == 0) rx_q.push_back('{ch: lr, data: w});
      end
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         codec_sclk  = 1'b0;
         codec_lrclk = lr;
         codec_sdin  = (i >= 1 && i <= 24) ? w[24-i] : 1'b0;
         repeat (4) @(negedge clk);
         if (i >= 1) begin
            if (cap && !aborted && i <= 24) begin
               check("sdout_bit", {31'b0, codec_sdout}, {31'b0, txw[24-i]});
               got = {got[22:0], codec_sdout};
            end else begin
               check("sdout_zero", {31'b0, codec_sdout}, 32'd0);
            end
         end
         codec_sclk = 1'b1;
         if (abort_kind != 0 && i == abort_at) begin
            aborted    = 1'b1;
            m_aligned  = 1'b0;
            prev_valid = 1'b0;
            @(negedge clk);
            if (abort_kind == 1) begin
               codec_rstn = 1'b0;
               repeat (3) @(posedge clk);
               #1;
               check("rstn_locked", {31'b0, locked}, 32'd0);
               check("rstn_sdout", {31'b0, codec_sdout}, 32'd0);
            end else begin
               rst = 1'b1;
               #1;
               check("rst_locked", {31'b0, locked}, 32'd0);
               check("rst_sdout", {31'b0, codec_sdout}, 32'd0);
               check("rst_rx_data", {8'b0, rx_data}, 32'd0);
               check("rst_rx_vld", {30'b0, rx_vld}, 32'd0);
               check("rst_tx_ack", {30'b0, tx_ack}, 32'd0);
               @(negedge clk);
               rst = 1'b0;
            end
         end
         repeat (3) @(negedge clk);
      end
      if (cap && !aborted && len > 24) check("sdout_word", {8'b0, got}, {8'b0, txw});
      if (cap && !aborted) check("locked_run", {31'b0, locked}, 32'd1);
      if (codec_rstn) begin
         prev_valid = 1'b1;
         prev_lr    = lr;
      end
   endtask

   initial begin
      rst         = 1'b1;
      codec_rstn  = 1'b0;
      codec_sclk  = 1'b0;
      codec_lrclk = 1'b0;
      codec_sdin  = 1'b0;
      tx_data0    = TX0;
      tx_data1    = TX1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_sdout", {31'b0, codec_sdout}, 32'd0);
      check("reset_rx_data", {8'b0, rx_data}, 32'd0);
      check("reset_rx_vld", {30'b0, rx_vld}, 32'd0);
      check("reset_tx_ack", {30'b0, tx_ack}, 32'd0);
      check("reset_locked", {31'b0, locked}, 32'd0);

      codec_rstn = 1'b1;
      repeat (4) @(negedge clk);
      send_slot(1'b1, 24'h000000, 10, 0, 0);
      check("locked_before_ws", {31'b0, locked}, 32'd0);

      send_slot(1'b0, 24'hABCDEF, 32, 0, 0);
      send_slot(1'b1, 24'h123456, 32, 0, 0);
      send_slot(1'b0, 24'hABCDEF, 32, 0, 0);
      send_slot(1'b1, 24'h123456, 32, 0, 0);
      check("rx_data_last_r", {8'b0, rx_data}, 32'h00123456);
`ifdef I2S_TARGET_FRAME_ERR_EN
      check("slot_err_clean", {31'b0, slot_err}, 32'd0);
`endif

      send_slot(1'b0, 24'hABCDEF, 32, 0, 0);
      send_slot(1'b1, 24'h654321, 36, 0, 0);
      send_slot(1'b0, 24'h111111, 16, 0, 0);
      send_slot(1'b1, 24'h123456, 32, 0, 0);
      send_slot(1'b0, 24'hABCDEF, 32, 0, 0);
      check("rx_data_after_short", {8'b0, rx_data}, 32'h00ABCDEF);
`ifdef I2S_TARGET_FRAME_ERR_EN
      check("slot_err_set", {31'b0, slot_err}, 32'd1);
`endif
      send_slot(1'b1, 24'h123456, 32, 0, 0);
`ifdef I2S_TARGET_FRAME_ERR_EN
      check("slot_err_sticky", {31'b0, slot_err}, 32'd1);
`endif

      send_slot(1'b0, 24'hABCDEF, 32, 1, 10);
      check("rstn_low_locked", {31'b0, locked}, 32'd0);
      codec_rstn = 1'b1;
      repeat (4) @(negedge clk);
      send_slot(1'b1, 24'h123456, 32, 0, 0);
      check("realign_pending", {31'b0, locked}, 32'd0);
      send_slot(1'b0, 24'h5A5A5A, 32, 0, 0);
      send_slot(1'b1, 24'h123456, 32, 0, 0);

      send_slot(1'b0, 24'hABCDEF, 32, 2, 10);
      send_slot(1'b1, 24'h0F0F0F, 32, 0, 0);
      send_slot(1'b0, 24'hABCDEF, 32, 0, 0);
      check("rx_data_final", {8'b0, rx_data}, 32'h00ABCDEF);

      repeat (20) @(negedge clk);
      check("rx_pending_left", rx_q.size(), 32'd0);
      check("tx_pending_left", tx_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
